// File: rtl/bp_nonsynth_io_responder.sv
// Behavioural BedRock I/O responder: terminates uncached read/write commands
// into a dword-addressed backing store and returns one in-order response per
// command after resp_delay_p idle cycles.
// Message layout (LSB first): msg_type[4], addr[paddr], size[3], payload, data.
module bp_nonsynth_io_responder
  #(parameter int paddr_width_p     = 40
  , parameter int cce_block_width_p = 128
  , parameter int lce_id_width_p    = 4
  , parameter int lce_assoc_p       = 8
  , parameter int dword_width_p     = 64
  , parameter int els_p             = 1024
  , parameter int resp_fifo_els_p   = 4
  , parameter int resp_delay_p      = 2
  , localparam int msg_type_width_lp    = 4
  , localparam int size_width_lp        = 3
  , localparam int payload_width_lp     = lce_id_width_p + $clog2(lce_assoc_p)
  , localparam int header_width_lp      = msg_type_width_lp + paddr_width_p + size_width_lp + payload_width_lp
  , localparam int cce_mem_msg_width_lp = header_width_lp + cce_block_width_p
  )
  (input  logic                            clk_i
  , input  logic                           reset_i
  , input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i
  , input  logic                           io_cmd_v_i
  , output logic                           io_cmd_yumi_o
  , output logic [cce_mem_msg_width_lp-1:0] io_resp_o
  , output logic                           io_resp_v_o
  , input  logic                           io_resp_ready_i
  , output logic [31:0]                    wr_count_o
  , output logic [31:0]                    rd_count_o
  , output logic                           error_o
  );

  localparam logic [msg_type_width_lp-1:0] uc_rd_lp  = 4'b0010;
  localparam logic [msg_type_width_lp-1:0] uc_wr_lp  = 4'b0011;
  localparam logic [size_width_lp-1:0]     size_4_lp = 3'b010;
  localparam logic [size_width_lp-1:0]     size_8_lp = 3'b011;

  localparam int idx_width_lp  = $clog2(els_p);
  localparam int ptr_width_lp  = (resp_fifo_els_p > 1) ? $clog2(resp_fifo_els_p) : 1;
  localparam int occ_width_lp  = $clog2(resp_fifo_els_p + 1);
  localparam int cnt_width_lp  = $clog2(resp_delay_p + 2);
  localparam int half_width_lp = dword_width_p / 2;

  typedef enum logic [1:0] {e_idle, e_wait, e_send} state_e;

  state_e                    state_r, state_n;
  logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
  logic [occ_width_lp-1:0]   occ_r, occ_n;
  logic [ptr_width_lp-1:0]   wr_ptr_r, rd_ptr_r;

  logic [header_width_lp-1:0] hdr_q  [resp_fifo_els_p];
  logic [dword_width_p-1:0]   data_q [resp_fifo_els_p];
  logic [dword_width_p-1:0]   mem_r  [els_p] = '{default: '0};

  // Command field decode
  logic [msg_type_width_lp-1:0] cmd_msg_type;
  logic [size_width_lp-1:0]     cmd_size;
  logic [idx_width_lp-1:0]      cmd_idx;
  logic                         cmd_hi;
  logic [dword_width_p-1:0]     cmd_data;
  logic                         size_ok, sup_wr, sup_rd, cmd_accept, deq;
  logic [dword_width_p-1:0]     rd_entry, wr_entry, acc_data;
  logic                         unused_cmd_data;

  assign cmd_msg_type = io_cmd_i[0 +: msg_type_width_lp];
  assign cmd_size     = io_cmd_i[msg_type_width_lp + paddr_width_p +: size_width_lp];
  assign cmd_idx      = io_cmd_i[msg_type_width_lp + 3 +: idx_width_lp];
  assign cmd_hi       = io_cmd_i[msg_type_width_lp + 2];
  assign cmd_data     = io_cmd_i[header_width_lp +: dword_width_p];
  assign unused_cmd_data = ^io_cmd_i[cce_mem_msg_width_lp-1 : header_width_lp + dword_width_p];

  assign size_ok = (cmd_size == size_4_lp) | (cmd_size == size_8_lp);
  assign sup_wr  = (cmd_msg_type == uc_wr_lp) & size_ok;
  assign sup_rd  = (cmd_msg_type == uc_rd_lp) & size_ok;

  // Occupancy is the registered count, so a same-cycle dequeue never frees a slot
  assign io_cmd_yumi_o = io_cmd_v_i & (occ_r < occ_width_lp'(resp_fifo_els_p)) & ~reset_i;
  assign cmd_accept    = io_cmd_yumi_o;
  assign io_resp_v_o   = (state_r == e_send);
  assign deq           = io_resp_v_o & io_resp_ready_i;

  assign rd_entry = mem_r[cmd_idx];

  // Merge write data into the addressed dword (sub-dword writes keep the other half)
  always_comb begin
    wr_entry = rd_entry;
    if (cmd_size == size_8_lp)
      wr_entry = cmd_data;
    else if (cmd_hi)
      wr_entry[half_width_lp +: half_width_lp] = cmd_data[0 +: half_width_lp];
    else
      wr_entry[0 +: half_width_lp] = cmd_data[0 +: half_width_lp];
  end

  // Response data captured at accept time; 4-byte reads replicate the selected half
  always_comb begin
    acc_data = '0;
    if (sup_rd) begin
      if (cmd_size == size_8_lp)
        acc_data = rd_entry;
      else if (cmd_hi)
        acc_data = {2{rd_entry[half_width_lp +: half_width_lp]}};
      else
        acc_data = {2{rd_entry[0 +: half_width_lp]}};
    end
  end

  // Backing store write; intentionally untouched by reset
  always_ff @(posedge clk_i) begin
    if (cmd_accept & sup_wr)
      mem_r[cmd_idx] <= wr_entry;
  end

  // Response FIFO storage
  always_ff @(posedge clk_i) begin
    if (cmd_accept) begin
      hdr_q[wr_ptr_r]  <= io_cmd_i[header_width_lp-1:0];
      data_q[wr_ptr_r] <= acc_data;
    end
  end

  // Next occupancy, accounting for simultaneous accept and dequeue
  always_comb begin
    occ_n = occ_r;
    if (cmd_accept & ~deq)
      occ_n = occ_r + 1'b1;
    else if (~cmd_accept & deq)
      occ_n = occ_r - 1'b1;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      occ_r <= occ_n;
      if (cmd_accept)
        wr_ptr_r <= (wr_ptr_r == ptr_width_lp'(resp_fifo_els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
      if (deq)
        rd_ptr_r <= (rd_ptr_r == ptr_width_lp'(resp_fifo_els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
    end
  end

  // Response FSM next state; leaving IDLE uses the next occupancy so an accept
  // in cycle t starts the delay immediately and the response is valid at t+1+delay
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    unique case (state_r)
      e_idle: begin
        if (occ_n != '0) begin
          if (resp_delay_p > 0) begin
            state_n = e_wait;
            cnt_n   = cnt_width_lp'(resp_delay_p);
          end else begin
            state_n = e_send;
          end
        end
      end
      e_wait: begin
        cnt_n = cnt_r - 1'b1;
        if (cnt_r == cnt_width_lp'(1))
          state_n = e_send;
      end
      e_send: begin
        if (deq) begin
          if (occ_n == '0) begin
            state_n = e_idle;
          end else if (resp_delay_p > 0) begin
            state_n = e_wait;
            cnt_n   = cnt_width_lp'(resp_delay_p);
          end else begin
            state_n = e_send;
          end
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Response message: echoed header plus zero-extended data from the FIFO head
  always_comb begin
    io_resp_o = '0;
    io_resp_o[header_width_lp-1:0]              = hdr_q[rd_ptr_r];
    io_resp_o[header_width_lp +: dword_width_p] = data_q[rd_ptr_r];
  end

  // Saturating access counters and sticky error flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_count_o <= '0;
      rd_count_o <= '0;
      error_o    <= 1'b0;
    end else if (cmd_accept) begin
      if (sup_wr && (wr_count_o != '1))
        wr_count_o <= wr_count_o + 1'b1;
      if (sup_rd && (rd_count_o != '1))
        rd_count_o <= rd_count_o + 1'b1;
      if (!(sup_wr || sup_rd))
        error_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_io_responder.sv
// Testbench for bp_nonsynth_io_responder: directed scenarios followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_bp_nonsynth_io_responder;

  localparam int PADDR = 40;
  localparam int BLK   = 128;
  localparam int PAY   = 7;
  localparam int HDR   = 4 + PADDR + 3 + PAY;
  localparam int W     = HDR + BLK;
  localparam int D     = 2;
  localparam int F     = 4;
  localparam int E     = 1024;

  localparam logic [3:0] UC_RD = 4'd2;
  localparam logic [3:0] UC_WR = 4'd3;
  localparam logic [2:0] SZ4   = 3'd2;
  localparam logic [2:0] SZ8   = 3'd3;
  localparam logic [2:0] SZ16  = 3'd4;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] io_cmd_i = '0;
  logic         io_cmd_v_i = 1'b0;
  logic         io_cmd_yumi_o;
  logic [W-1:0] io_resp_o;
  logic         io_resp_v_o;
  logic         io_resp_ready_i = 1'b0;
  logic [31:0]  wr_count_o, rd_count_o;
  logic         error_o;

  bp_nonsynth_io_responder #(.els_p(E), .resp_fifo_els_p(F), .resp_delay_p(D)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_yumi_o(io_cmd_yumi_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i),
    .wr_count_o(wr_count_o), .rd_count_o(rd_count_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference model state
  typedef struct { logic [W-1:0] msg; longint acc; } exp_t;
  exp_t         q[$];
  logic [63:0]  mmem [E] = '{default: '0};
  logic [31:0]  m_wr = '0;
  logic [31:0]  m_rd = '0;
  logic         m_err = 1'b0;
  longint       last_hs = -1000;
  logic [63:0]  last_data = '0;
  longint       acc_cyc = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [3:0] mt, input logic [PADDR-1:0] a,
                                      input logic [2:0] sz, input logic [PAY-1:0] pl,
                                      input logic [BLK-1:0] d);
    return {d, pl, sz, a, mt};
  endfunction

  // Apply the accepted command currently on io_cmd_i to the model
  task automatic model_accept();
    logic [3:0]       mt;
    logic [PADDR-1:0] a;
    logic [2:0]       sz;
    logic [PAY-1:0]   pl;
    logic [63:0]      d, rdata, ent;
    logic [31:0]      h;
    int               idx;
    mt = io_cmd_i[3:0];
    a  = io_cmd_i[4 +: PADDR];
    sz = io_cmd_i[4 + PADDR +: 3];
    pl = io_cmd_i[4 + PADDR + 3 +: PAY];
    d  = io_cmd_i[HDR +: 64];
    idx = int'(a[12:3]);
    rdata = '0;
    ent = mmem[idx];
    if (!((mt == UC_RD || mt == UC_WR) && (sz == SZ4 || sz == SZ8))) begin
      m_err = 1'b1;
    end else if (mt == UC_WR) begin
      m_wr = m_wr + 1;
      if (sz == SZ8) ent = d;
      else if (a[2]) ent[63:32] = d[31:0];
      else ent[31:0] = d[31:0];
      mmem[idx] = ent;
    end else begin
      m_rd = m_rd + 1;
      if (sz == SZ8) rdata = ent;
      else begin
        h = a[2] ? ent[63:32] : ent[31:0];
        rdata = {h, h};
      end
    end
    q.push_back('{msg: mk(mt, a, sz, pl, BLK'(rdata)), acc: cyc});
  endtask

  // Cycle monitor: responses become valid delay cycles after the later of their
  // acceptance and the previous handshake, and stay valid until taken
  always @(negedge clk) begin
    logic   exp_yumi, exp_v;
    longint rdy_at;
    if (reset_i) begin
      chk("yumi_in_reset", W'(io_cmd_yumi_o), W'(1'b0));
      q.delete();
      m_wr = '0; m_rd = '0; m_err = 1'b0;
      last_hs = -1000;
    end else begin
      exp_yumi = io_cmd_v_i && (q.size() < F);
      exp_v = 1'b0;
      if (q.size() > 0) begin
        rdy_at = ((q[0].acc > last_hs) ? q[0].acc : last_hs) + 1 + D;
        exp_v = (cyc >= rdy_at);
      end
      chk("yumi", W'(io_cmd_yumi_o), W'(exp_yumi));
      chk("resp_v", W'(io_resp_v_o), W'(exp_v));
      chk("wr_count", W'(wr_count_o), W'(m_wr));
      chk("rd_count", W'(rd_count_o), W'(m_rd));
      chk("error", W'(error_o), W'(m_err));
      if (exp_v) chk("resp_msg", io_resp_o, q[0].msg);
      if (exp_v && io_resp_ready_i) begin
        last_data = io_resp_o[HDR +: 64];
        void'(q.pop_front());
        last_hs = cyc;
      end
      if (exp_yumi) model_accept();
    end
  end

  task automatic send_cmd(input logic [3:0] mt, input logic [PADDR-1:0] a,
                          input logic [2:0] sz, input logic [63:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    io_cmd_i = mk(mt, a, sz, PAY'($urandom), {32'($urandom), 32'($urandom), d});
    io_cmd_v_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (io_cmd_yumi_o) begin got = 1'b1; acc_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    io_cmd_v_i = 1'b0;
    if (!got) chk("cmd_accept_timeout", W'(1'b0), W'(1'b1));
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (q.size() == 0) begin done = 1'b1; break; end
    end
    chk("drain", W'(done), W'(1'b1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset_i = 1'b1;
    @(posedge clk); #1; reset_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] snap_rd;
    logic [3:0]  mt;
    logic [2:0]  sz;
    logic [PADDR-1:0] a;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("rst_resp_v", W'(io_resp_v_o), W'(1'b0));
    chk("rst_wr_count", W'(wr_count_o), W'(0));
    chk("rst_rd_count", W'(rd_count_o), W'(0));
    chk("rst_error", W'(error_o), W'(1'b0));

    // Full-dword write then read back
    io_resp_ready_i = 1'b1;
    send_cmd(UC_WR, 40'h8, SZ8, 64'h1122334455667788);
    send_cmd(UC_RD, 40'h8, SZ8, 64'h0);
    drain();
    chk("rd8_data", W'(last_data), W'(64'h1122334455667788));
    chk("wr_count_1", W'(wr_count_o), W'(1));
    chk("rd_count_1", W'(rd_count_o), W'(1));

    // Half-dword write, full and half reads
    send_cmd(UC_WR, 40'h14, SZ4, 64'h00000000DEADBEEF);
    send_cmd(UC_RD, 40'h10, SZ8, 64'h0);
    drain();
    chk("rd8_after_wr4", W'(last_data), W'(64'hDEADBEEF00000000));
    send_cmd(UC_RD, 40'h14, SZ4, 64'h0);
    drain();
    chk("rd4_replicated", W'(last_data), W'(64'hDEADBEEFDEADBEEF));

    // Latency: valid exactly at accept+1+D for one cycle with ready high
    send_cmd(UC_WR, 40'h100, SZ8, 64'h55);
    @(negedge clk); chk("lat_t1", W'(io_resp_v_o), W'(1'b0));
    @(negedge clk); chk("lat_t2", W'(io_resp_v_o), W'(1'b0));
    @(negedge clk); chk("lat_t3", W'(io_resp_v_o), W'(1'b1));
    @(negedge clk); chk("lat_t4", W'(io_resp_v_o), W'(1'b0));
    drain();

    // Backpressure: four outstanding fill the FIFO, fifth waits
    io_resp_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) send_cmd(UC_RD, 40'(k * 8), SZ8, 64'h0);
    @(posedge clk); #1;
    io_cmd_i = mk(UC_RD, 40'h20, SZ8, 7'h5, '0);
    io_cmd_v_i = 1'b1;
    repeat (4) begin @(negedge clk); chk("full_hold", W'(io_cmd_yumi_o), W'(1'b0)); end
    @(posedge clk); #1; io_resp_ready_i = 1'b1;
    @(negedge clk); chk("full_same_cycle", W'(io_cmd_yumi_o), W'(1'b0));
    @(negedge clk); chk("full_after_hs", W'(io_cmd_yumi_o), W'(1'b1));
    @(posedge clk); #1; io_cmd_v_i = 1'b0;
    drain();

    // Unsupported size: zero-data response, sticky error, counters unchanged
    @(posedge clk); #1; snap_rd = m_rd;
    send_cmd(UC_RD, 40'h40, SZ16, 64'h0);
    drain();
    chk("bad_err", W'(error_o), W'(1'b1));
    chk("bad_rd_count", W'(rd_count_o), W'(snap_rd));
    chk("bad_data", W'(last_data), W'(64'h0));
    send_cmd(UC_WR, 40'h48, SZ8, 64'h77);
    drain();
    chk("err_sticky", W'(error_o), W'(1'b1));
    do_reset();
    @(negedge clk); chk("err_cleared", W'(error_o), W'(1'b0));

    // Aliasing: address E*8 maps onto dword 0
    send_cmd(UC_WR, 40'h0, SZ8, 64'hCAFEF00D12345678);
    send_cmd(UC_RD, 40'(E * 8), SZ8, 64'h0);
    drain();
    chk("alias_data", W'(last_data), W'(64'hCAFEF00D12345678));

    // Reset with pending responses drops them
    io_resp_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) send_cmd(UC_RD, 40'(k * 8), SZ8, 64'h0);
    do_reset();
    io_resp_ready_i = 1'b1;
    repeat (8) begin @(negedge clk); chk("no_stale", W'(io_resp_v_o), W'(1'b0)); end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset_i = (i == 1500);
      io_cmd_v_i = ($urandom_range(0, 3) != 0);
      io_resp_ready_i = ($urandom_range(0, 2) != 0);
      mt = ($urandom_range(0, 15) == 0) ? 4'($urandom) : (($urandom_range(0, 1) != 0) ? UC_WR : UC_RD);
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom) : (($urandom_range(0, 1) != 0) ? SZ8 : SZ4);
      a = {8'($urandom), 32'($urandom)};
      a[12:7] = '0;
      io_cmd_i = mk(mt, a, sz, PAY'($urandom),
                    {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});
    end
    @(posedge clk); #1;
    reset_i = 1'b0;
    io_cmd_v_i = 1'b0;
    io_resp_ready_i = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
